// File: rtl/ups_axi4l_regfile.sv
// ============================================================================
//  Module      : ups_axi4l_regfile
//  Description : AXI4-Lite slave holding UPS CTRL/CFG registers plus STATUS/ID.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ups_axi4l_regfile #(
    parameter logic [31:0] ID_VALUE = 32'h5550_0100,
    parameter bit          STRB_EN  = 1'b0,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ca4l_araddr,
    input  logic [2:0]  ca4l_arprot,
    input  logic        ca4l_arvalid,
    output logic        ca4l_arready,
    output logic [31:0] ca4l_rdata,
    output logic [1:0]  ca4l_rresp,
    output logic        ca4l_rvalid,
    input  logic        ca4l_rready,
    input  logic [31:0] ca4l_awaddr,
    input  logic [2:0]  ca4l_awprot,
    input  logic        ca4l_awvalid,
    output logic        ca4l_awready,
    input  logic [31:0] ca4l_wdata,
    input  logic [3:0]  ca4l_wstrb,
    input  logic        ca4l_wvalid,
    output logic        ca4l_wready,
    output logic [1:0]  ca4l_bresp,
    output logic        ca4l_bvalid,
    input  logic        ca4l_bready,
    input  logic [31:0] status_in,
    output logic [3:0]  led,
    output logic [31:0] ctrl,
    output logic [31:0] cfg0,
    output logic [31:0] cfg1,
    output logic        ctrl_wr_pulse
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [2:0] c_SEL_CTRL   = 3'd0;
    localparam logic [2:0] c_SEL_CFG0   = 3'd1;
    localparam logic [2:0] c_SEL_CFG1   = 3'd2;
    localparam logic [2:0] c_SEL_STATUS = 3'd3;
    localparam logic [2:0] c_SEL_ID     = 3'd4;
    localparam logic [2:0] c_SEL_NONE   = 3'd7;

    // Word address in, register select out; any high bit set means unmapped.
    function automatic logic [2:0] f_decode(input logic [29:0] word);
        logic [2:0] sel;
        sel = c_SEL_NONE;
        if (word[29:3] == '0) begin
            case (word[2:0])
                3'd0:    sel = c_SEL_CTRL;
                3'd1:    sel = c_SEL_CFG0;
                3'd2:    sel = c_SEL_CFG1;
                3'd3:    sel = c_SEL_STATUS;
                3'd4:    sel = c_SEL_ID;
                default: sel = c_SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    wstate_t     r_wstate, w_wstate_nxt;
    rstate_t     r_rstate, w_rstate_nxt;
    logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic [29:0] r_awaddr;
    logic [31:0] r_ctrl, r_cfg0, r_cfg1;
    logic        r_ctrl_wr_pulse;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [2:0]  w_wsel, w_rsel;
    logic [31:0] w_wmask;
    logic [1:0]  w_wresp;
    logic [31:0] w_rdata_mux;
    logic [1:0]  w_rresp_mux;
    logic        w_unused;

    assign w_aw_hs = ca4l_awvalid & r_awready;
    assign w_w_hs  = ca4l_wvalid  & r_wready;
    assign w_b_hs  = r_bvalid     & ca4l_bready;
    assign w_ar_hs = ca4l_arvalid & r_arready;
    assign w_r_hs  = r_rvalid     & ca4l_rready;

    assign w_wsel  = f_decode(r_awaddr);
    assign w_rsel  = f_decode(ca4l_araddr[31:2]);
    assign w_wmask = STRB_EN ? {{8{ca4l_wstrb[3]}}, {8{ca4l_wstrb[2]}},
                                {8{ca4l_wstrb[1]}}, {8{ca4l_wstrb[0]}}} : '1;
    assign w_unused = ^{ca4l_arprot, ca4l_awprot, ca4l_araddr[1:0], ca4l_awaddr[1:0]};

    always_comb begin
        w_wresp = c_RESP_DECERR;
        case (w_wsel)
            c_SEL_CTRL, c_SEL_CFG0, c_SEL_CFG1: w_wresp = c_RESP_OKAY;
            c_SEL_STATUS, c_SEL_ID:             w_wresp = c_RESP_SLVERR;
            default:                            w_wresp = c_RESP_DECERR;
        endcase
    end

    always_comb begin
        w_rdata_mux = '0;
        w_rresp_mux = c_RESP_OKAY;
        case (w_rsel)
            c_SEL_CTRL:   w_rdata_mux = r_ctrl;
            c_SEL_CFG0:   w_rdata_mux = r_cfg0;
            c_SEL_CFG1:   w_rdata_mux = r_cfg1;
            c_SEL_STATUS: w_rdata_mux = status_in;
            c_SEL_ID:     w_rdata_mux = ID_VALUE;
            default:      w_rresp_mux = c_RESP_DECERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)  w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write channel: the register is updated on the very edge of the W handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awready       <= 1'b0;
            r_wready        <= 1'b0;
            r_bvalid        <= 1'b0;
            r_bresp         <= c_RESP_OKAY;
            r_awaddr        <= '0;
            r_ctrl          <= CTRL_RST;
            r_cfg0          <= '0;
            r_cfg1          <= '0;
            r_ctrl_wr_pulse <= 1'b0;
        end else begin
            r_ctrl_wr_pulse <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= ~w_aw_hs;
                    if (w_aw_hs) begin
                        r_awaddr <= ca4l_awaddr[31:2];
                        r_wready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wready        <= 1'b0;
                        r_bvalid        <= 1'b1;
                        r_bresp         <= w_wresp;
                        r_ctrl_wr_pulse <= (w_wsel == c_SEL_CTRL);
                        case (w_wsel)
                            c_SEL_CTRL: r_ctrl <= f_merge(r_ctrl, ca4l_wdata, w_wmask);
                            c_SEL_CFG0: r_cfg0 <= f_merge(r_cfg0, ca4l_wdata, w_wmask);
                            c_SEL_CFG1: r_cfg1 <= f_merge(r_cfg1, ca4l_wdata, w_wmask);
                            default: ;
                        endcase
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read channel: data and response are captured at the AR handshake and held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= ~w_ar_hs;
                    if (w_ar_hs) begin
                        r_rdata  <= w_rdata_mux;
                        r_rresp  <= w_rresp_mux;
                        r_rvalid <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ca4l_awready  = r_awready;
    assign ca4l_wready   = r_wready;
    assign ca4l_bvalid   = r_bvalid;
    assign ca4l_bresp    = r_bresp;
    assign ca4l_arready  = r_arready;
    assign ca4l_rvalid   = r_rvalid;
    assign ca4l_rdata    = r_rdata;
    assign ca4l_rresp    = r_rresp;
    assign ctrl          = r_ctrl;
    assign cfg0          = r_cfg0;
    assign cfg1          = r_cfg1;
    assign led           = r_ctrl[3:0];
    assign ctrl_wr_pulse = r_ctrl_wr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_ups_axi4l_regfile.sv
// ============================================================================
//  Module      : tb_ups_axi4l_regfile
//  Description : Bench driving a strobe-aware and a full-word regfile in lockstep.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ups_axi4l_regfile;

    localparam logic [31:0] c_ID       = 32'h5550_0100;
    localparam logic [31:0] c_CRST_F   = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, status_in = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic        arready_s, rvalid_s, awready_s, wready_s, bvalid_s, pulse_s;
    logic        arready_f, rvalid_f, awready_f, wready_f, bvalid_f, pulse_f;
    logic [31:0] rdata_s, ctrl_s, cfg0_s, cfg1_s, rdata_f, ctrl_f, cfg0_f, cfg1_f;
    logic [1:0]  rresp_s, bresp_s, rresp_f, bresp_f;
    logic [3:0]  led_s, led_f;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: [0] honours strobes, [1] always writes the whole word.
    logic [31:0] m_reg [2][3];

    always #5 clk = ~clk;

    ups_axi4l_regfile #(.ID_VALUE(c_ID), .STRB_EN(1'b1), .CTRL_RST(32'h0)) u_dut_s (
        .clk(clk), .rst(rst),
        .ca4l_araddr(araddr), .ca4l_arprot(3'b000), .ca4l_arvalid(arvalid), .ca4l_arready(arready_s),
        .ca4l_rdata(rdata_s), .ca4l_rresp(rresp_s), .ca4l_rvalid(rvalid_s), .ca4l_rready(rready),
        .ca4l_awaddr(awaddr), .ca4l_awprot(3'b000), .ca4l_awvalid(awvalid), .ca4l_awready(awready_s),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready_s),
        .ca4l_bresp(bresp_s), .ca4l_bvalid(bvalid_s), .ca4l_bready(bready),
        .status_in(status_in), .led(led_s), .ctrl(ctrl_s), .cfg0(cfg0_s), .cfg1(cfg1_s),
        .ctrl_wr_pulse(pulse_s)
    );

    ups_axi4l_regfile #(.ID_VALUE(c_ID), .STRB_EN(1'b0), .CTRL_RST(c_CRST_F)) u_dut_f (
        .clk(clk), .rst(rst),
        .ca4l_araddr(araddr), .ca4l_arprot(3'b101), .ca4l_arvalid(arvalid), .ca4l_arready(arready_f),
        .ca4l_rdata(rdata_f), .ca4l_rresp(rresp_f), .ca4l_rvalid(rvalid_f), .ca4l_rready(rready),
        .ca4l_awaddr(awaddr), .ca4l_awprot(3'b101), .ca4l_awvalid(awvalid), .ca4l_awready(awready_f),
        .ca4l_wdata(wdata), .ca4l_wstrb(wstrb), .ca4l_wvalid(wvalid), .ca4l_wready(wready_f),
        .ca4l_bresp(bresp_f), .ca4l_bvalid(bvalid_f), .ca4l_bready(bready),
        .status_in(status_in), .led(led_f), .ctrl(ctrl_f), .cfg0(cfg0_f), .cfg1(cfg1_f),
        .ctrl_wr_pulse(pulse_f)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mkv(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                 int m, logic [1:0] r, logic [31:0] rd);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
        v.mode = m; v.exp_resp = r; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 3; r++) m_reg[k][r] = '0;
        m_reg[1][0] = c_CRST_F;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [1:0] exp_wresp(input logic [31:0] a);
        case (word_of(a))
            32'h00, 32'h04, 32'h08: return 2'b00;
            32'h0C, 32'h10:         return 2'b10;
            default:                return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] a);
        case (word_of(a))
            32'h00, 32'h04, 32'h08, 32'h0C, 32'h10: return 2'b00;
            default:                                return 2'b11;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input logic [31:0] a, input logic [31:0] st);
        case (word_of(a))
            32'h00:  return m_reg[k][0];
            32'h04:  return m_reg[k][1];
            32'h08:  return m_reg[k][2];
            32'h0C:  return st;
            32'h10:  return c_ID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] msk;
        case (word_of(a))
            32'h00:  idx = 0;
            32'h04:  idx = 1;
            32'h08:  idx = 2;
            default: idx = -1;
        endcase
        if (idx >= 0) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 4; b++) msk[b*8 +: 8] = {8{(k == 1) || s[b]}};
                m_reg[k][idx] = (m_reg[k][idx] & ~msk) | (d & msk);
            end
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " ctrl_s"}, ctrl_s, m_reg[0][0]);
        chk({tag, " cfg0_s"}, cfg0_s, m_reg[0][1]);
        chk({tag, " cfg1_s"}, cfg1_s, m_reg[0][2]);
        chk({tag, " led_s"},  {28'b0, led_s}, {28'b0, m_reg[0][0][3:0]});
        chk({tag, " ctrl_f"}, ctrl_f, m_reg[1][0]);
        chk({tag, " cfg0_f"}, cfg0_f, m_reg[1][1]);
        chk({tag, " cfg1_f"}, cfg1_f, m_reg[1][2]);
        chk({tag, " led_f"},  {28'b0, led_f}, {28'b0, m_reg[1][0][3:0]});
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0:       return awready_s & awready_f;
            1:       return wready_s & wready_f;
            default: return arready_s & arready_f;
        endcase
    endfunction

    // Waits (bounded) for the ready, then steps through the handshake edge.
    task automatic wait_hs(input int w, input string name);
        int n = 0;
        while (!rdy(w) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'b0, rdy(w)}, 32'h1);
        if (rdy(w)) begin
            @(posedge clk); #1;
        end
    endtask

    // mode 0: W one clock after AW; 1: W raised together with AW; 2: W right after AW.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input bit hold_b, output logic [1:0] resp_f);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = (mode == 1);
        wait_hs(0, "awready");
        awvalid = 1'b0;
        chk("awready_drop", {31'b0, awready_s}, 32'h0);
        chk("bvalid_early", {31'b0, bvalid_s | bvalid_f}, 32'h0);
        if (mode == 0) begin
            @(posedge clk); #1;
        end
        wvalid = 1'b1;
        wait_hs(1, "wready");
        wvalid = 1'b0;
        model_write(a, d, s);
        chk("bvalid", {30'b0, bvalid_s, bvalid_f}, 32'h3);
        chk("bresp_s", {30'b0, bresp_s}, {30'b0, exp_wresp(a)});
        chk("bresp_f", {30'b0, bresp_f}, {30'b0, exp_wresp(a)});
        chk("wr_pulse", {30'b0, pulse_s, pulse_f}, (word_of(a) == 32'h0) ? 32'h3 : 32'h0);
        chk_regs("wr");
        resp_f = bresp_f;
        if (!hold_b) begin
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
            chk("wr_pulse_end", {30'b0, pulse_s, pulse_f}, 32'h0);
            chk("bvalid_end", {30'b0, bvalid_s, bvalid_f}, 32'h0);
            chk("awready_back", {30'b0, awready_s, awready_f}, 32'h3);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd_s, output logic [31:0] rd_f,
                           output logic [1:0] rr_s, output logic [1:0] rr_f);
        araddr = a; arvalid = 1'b1;
        wait_hs(2, "arready");
        arvalid = 1'b0;
        chk("rvalid", {30'b0, rvalid_s, rvalid_f}, 32'h3);
        chk("arready_drop", {31'b0, arready_s}, 32'h0);
        rd_s = rdata_s; rd_f = rdata_f; rr_s = rresp_s; rr_f = rresp_f;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_end", {30'b0, rvalid_s, rvalid_f}, 32'h0);
        chk("arready_back", {30'b0, arready_s, arready_f}, 32'h3);
    endtask

    task automatic rd_check(input logic [31:0] a);
        logic [31:0] rs, rf;
        logic [1:0]  ps, pf;
        do_read(a, rs, rf, ps, pf);
        chk("rdata_s", rs, exp_rd(0, a, status_in));
        chk("rdata_f", rf, exp_rd(1, a, status_in));
        chk("rresp_s", {30'b0, ps}, {30'b0, exp_rresp(a)});
        chk("rresp_f", {30'b0, pf}, {30'b0, exp_rresp(a)});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_s, rd_f, old_s, old_f, a;
        logic [1:0]  rr_s, rr_f, resp;

        vecs[0]  = mkv(1, 32'h00, 32'h2,    4'h0, 2, 2'b00, 32'h0);
        vecs[1]  = mkv(0, 32'h00, 32'h0,    4'h0, 0, 2'b00, 32'h2);
        vecs[2]  = mkv(1, 32'h04, 32'h11,   4'hF, 0, 2'b00, 32'h0);
        vecs[3]  = mkv(0, 32'h04, 32'h0,    4'h0, 0, 2'b00, 32'h11);
        vecs[4]  = mkv(1, 32'h08, 32'hC38D, 4'hF, 1, 2'b00, 32'h0);
        vecs[5]  = mkv(0, 32'h08, 32'h0,    4'h0, 0, 2'b00, 32'hC38D);
        vecs[6]  = mkv(1, 32'h10, 32'hDEAD, 4'hF, 2, 2'b10, 32'h0);
        vecs[7]  = mkv(0, 32'h10, 32'h0,    4'h0, 0, 2'b00, c_ID);
        vecs[8]  = mkv(1, 32'h40, 32'h1234, 4'hF, 0, 2'b11, 32'h0);
        vecs[9]  = mkv(0, 32'h40, 32'h0,    4'h0, 0, 2'b11, 32'h0);
        vecs[10] = mkv(1, 32'h0C, 32'h1,    4'hF, 1, 2'b10, 32'h0);
        vecs[11] = mkv(0, 32'h0C, 32'h0,    4'h0, 0, 2'b00, 32'h1357_9BDF);
        vecs[12] = mkv(0, 32'h03, 32'h0,    4'h0, 0, 2'b00, 32'h2);
        vecs[13] = mkv(1, 32'h14, 32'h77,   4'hF, 0, 2'b11, 32'h0);
        vecs[14] = mkv(0, 32'h1000_0004, 32'h0, 4'h0, 0, 2'b11, 32'h0);
        vecs[15] = mkv(0, 32'h1C, 32'h0,    4'h0, 0, 2'b11, 32'h0);

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {28'b0, awready_s, arready_s, awready_f, arready_f}, 32'h0);
        chk("rst_valid", {28'b0, wready_s, bvalid_s, rvalid_s, rvalid_f}, 32'h0);
        chk("rst_rdata", rdata_s | rdata_f, 32'h0);
        chk("rst_resp", {24'b0, rresp_s, bresp_s, rresp_f, bresp_f}, 32'h0);
        chk("rst_pulse", {30'b0, pulse_s, pulse_f}, 32'h0);
        chk_regs("rst");
        rst = 1'b0;
        chk("awready_pre_edge", {31'b0, awready_s}, 32'h0);
        @(posedge clk); #1;
        chk("awready_rise", {28'b0, awready_s, arready_s, awready_f, arready_f}, 32'hF);

        // Directed table
        status_in = 32'h1357_9BDF;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode, 1'b0, resp);
                chk($sformatf("tbl%0d bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end else begin
                do_read(vecs[i].addr, rd_s, rd_f, rr_s, rr_f);
                chk($sformatf("tbl%0d rdata_f", i), rd_f, vecs[i].exp_rdata);
                chk($sformatf("tbl%0d rresp_f", i), {30'b0, rr_f}, {30'b0, vecs[i].exp_resp});
                chk($sformatf("tbl%0d rdata_s", i), rd_s, exp_rd(0, vecs[i].addr, status_in));
                chk($sformatf("tbl%0d rresp_s", i), {30'b0, rr_s}, {30'b0, vecs[i].exp_resp});
            end
        end

        // Byte strobes
        do_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, resp);
        do_write(32'h08, 32'h1234_5678, 4'b0101, 2, 1'b0, resp);
        chk("strb_cfg1_s", cfg1_s, 32'hFF34_FF78);
        chk("strb_cfg1_f", cfg1_f, 32'h1234_5678);

        // Read and W handshake on the same edge: read sees the old value
        old_s = m_reg[0][1];
        old_f = m_reg[1][1];
        awaddr = 32'h04; awvalid = 1'b1;
        wait_hs(0, "sim_awready");
        awvalid = 1'b0;
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        chk("sim_ready", {28'b0, wready_s, arready_s, wready_f, arready_f}, 32'hF);
        @(posedge clk); #1;
        wvalid = 1'b0; arvalid = 1'b0;
        model_write(32'h04, 32'h0BAD_F00D, 4'hF);
        chk("sim_valid", {28'b0, bvalid_s, rvalid_s, bvalid_f, rvalid_f}, 32'hF);
        chk("sim_old_s", rdata_s, old_s);
        chk("sim_old_f", rdata_f, old_f);
        chk_regs("sim");
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        rd_check(32'h04);

        // Read backpressure with a changing status word
        status_in = 32'hA5A5_A5A5;
        araddr = 32'h0C; arvalid = 1'b1;
        wait_hs(2, "bp_arready");
        arvalid = 1'b0;
        status_in = 32'h0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d rvalid", c), {30'b0, rvalid_s, rvalid_f}, 32'h3);
            chk($sformatf("bp%0d rdata", c), rdata_s, 32'hA5A5_A5A5);
            chk($sformatf("bp%0d arready", c), {30'b0, arready_s, arready_f}, 32'h0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("bp_done", {30'b0, rvalid_s, rvalid_f}, 32'h0);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h00;
                1: a = 32'h04;
                2: a = 32'h08;
                3: a = 32'h0C;
                4: a = 32'h10;
                5: a = 32'h14;
                6: a = 32'h1C;
                default: a = $urandom() | 32'h100;
            endcase
            a = a | 32'($urandom_range(0, 3));
            status_in = $urandom();
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom(), 4'($urandom()), $urandom_range(0, 2), 1'b0, resp);
            else
                rd_check(a);
        end

        // Reset while a CTRL write waits in W_RESP
        do_write(32'h00, 32'hF, 4'hF, 2, 1'b1, resp);
        @(posedge clk); #1;
        chk("hold_bvalid", {30'b0, bvalid_s, bvalid_f}, 32'h3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_bvalid", {30'b0, bvalid_s, bvalid_f}, 32'h0);
        chk("arst_ready", {28'b0, awready_s, arready_s, awready_f, arready_f}, 32'h0);
        chk_regs("arst");
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_awready_low", {30'b0, awready_s, awready_f}, 32'h0);
        @(posedge clk); #1;
        chk("arst_awready_rise", {30'b0, awready_s, awready_f}, 32'h3);
        rd_check(32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ups_axi4l_regfile.md
Name: ups_axi4l_regfile

Overview:
- AXI4-Lite slave register file that directly consumes the ca4l_* master port of the UPS Zynq wrapper.
- Holds the UPS control and configuration registers, drives the board LEDs and control outputs, and returns status and ID words.
- Write and read channels are handled by independent state machines, one transaction per channel at a time.
- Supports masters that present AW and W in separate cycles, i.e. AW first and W only after the AW handshake.

Parameters:
- ID_VALUE, 32'h5550_0100: constant returned at 0x10.
- STRB_EN, 0: 1 = honour ca4l_wstrb per byte; 0 = ignore wstrb and write all 4 bytes.
- CTRL_RST, 32'h0: reset value of CTRL.

Ports:
- clk in 1: fclk domain, rising edge.
- rst in 1: asynchronous, active-high reset.
- ca4l_araddr in 32: read address.
- ca4l_arprot in 3: ignored.
- ca4l_arvalid in 1: read address valid.
- ca4l_arready out 1: read address ready.
- ca4l_rdata out 32: read data.
- ca4l_rresp out 2: read response.
- ca4l_rvalid out 1: read data valid.
- ca4l_rready in 1: read data ready.
- ca4l_awaddr in 32: write address.
- ca4l_awprot in 3: ignored.
- ca4l_awvalid in 1: write address valid.
- ca4l_awready out 1: write address ready.
- ca4l_wdata in 32: write data.
- ca4l_wstrb in 4: byte strobes.
- ca4l_wvalid in 1: write data valid.
- ca4l_wready out 1: write data ready.
- ca4l_bresp out 2: write response.
- ca4l_bvalid out 1: write response valid.
- ca4l_bready in 1: write response ready.
- status_in in 32: live status word, sampled on read.
- led out 4: CTRL[3:0].
- ctrl out 32: CTRL register.
- cfg0 out 32: CFG0 register.
- cfg1 out 32: CFG1 register.
- ctrl_wr_pulse out 1: one-cycle pulse after any accepted CTRL write.

Behaviour:
- Reset (async, rst=1):
  - ready/valid outputs: 0.
  - Data outputs: ca4l_rdata=0, ca4l_rresp=0, ca4l_bresp=0.
  - Registers: CTRL=CTRL_RST, CFG0=0, CFG1=0.
  - ctrl_wr_pulse=0.
  - Both FSMs go to IDLE.
- Reset release: awready and arready rise on the first clk edge after rst deasserts.
- Register map (byte address, addr[1:0] ignored):
  - 0x00 CTRL rw.
  - 0x04 CFG0 rw.
  - 0x08 CFG1 rw.
  - 0x0C STATUS ro (status_in).
  - 0x10 ID ro (ID_VALUE).
  - Anything else is unmapped, including any nonzero bit in [31:5].
- Responses:
  - OKAY 2'b00.
  - Write to a ro register: SLVERR 2'b10, no effect.
  - Unmapped address: DECERR 2'b11. Writes are dropped; reads return 0.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready: latch awaddr; awready<=0; wready<=1; go to W_DATA.
  - W_DATA: wready=1. On wvalid&wready:
    - Update the target register in the same edge (byte-masked if STRB_EN=1).
    - Set bresp; wready<=0; bvalid<=1; go to W_RESP.
    - If the target is CTRL, ctrl_wr_pulse=1 in the following cycle only.
  - W_RESP: hold bvalid and bresp until bready. On bvalid&bready: bvalid<=0; awready<=1; go to W_IDLE.
  - wvalid seen in W_IDLE is not accepted (wready=0) until AW completes.
  - AW and W presented together still take two handshakes: AW, then W on the next cycle.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready:
    - Decode araddr; rdata<=selected value, with STATUS sampled at this edge.
    - Set rresp; arready<=0; rvalid<=1; go to R_DATA.
  - R_DATA: hold rdata, rresp and rvalid stable until rready. On rvalid&rready: rvalid<=0; arready<=1; go to R_IDLE.
- Latency:
  - rvalid rises 1 cycle after the AR handshake.
  - Register outputs change 1 cycle after the W handshake.
  - bvalid rises together with the register update.
- Simultaneous read and write of the same register:
  - Read handshake on the same edge as the W handshake returns the old value.
  - A later read returns the new value.
- Read and write channels never block each other.
- led, ctrl, cfg0 and cfg1 are direct register outputs with no combinational path from the bus.
- Reset mid-transaction: the transaction is abandoned immediately, outputs go to their reset values, and no partial write occurs.

Test Plan:
- Basic write/read: write 0x00=0x2 with wstrb=0 and STRB_EN=0, then read 0x00 -> bresp=OKAY, led=4'b0010, ctrl_wr_pulse for exactly 1 cycle, read data 0x00000002 OKAY.
- Separate AW/W timing: write 0x04=0x11 using AW, then W one clock later, then read 0x04 -> cfg0=0x11, read data 0x00000011; write 0x08=0xC38D -> cfg1=0x0000C38D.
- Strobes: STRB_EN=1, CFG1=0xFFFFFFFF, write 0x08=0x12345678 with wstrb=4'b0101 -> cfg1=0xFF34FF78.
- Errors:
  - Write 0x10 -> SLVERR, ID unchanged.
  - Write 0x40 -> DECERR, no register changes.
  - Read 0x40 -> rdata=0, DECERR.
  - Read 0x10 -> ID_VALUE, OKAY.
- Backpressure and status: hold rready=0 for 10 cycles after reading 0x0C with status_in=0xA5A5A5A5, changing status_in to 0 meanwhile -> rvalid held, rdata stays 0xA5A5A5A5, arready=0 throughout.
- Reset: assert rst while in W_RESP after a CTRL write of 0xF -> bvalid=0 immediately, led=0; awready=1 one cycle after release; a fresh read of 0x00 returns CTRL_RST.
